bidir_shift_sequencer: RTL and testbench
========================================

// Module: bidir_shift_sequencer
// PURPOSE
//  Sequences a WIDTH-bit bidirectional shift register through one full serial transfer.
//  - Accepts a parallel word and a direction over a valid/ready handshake.
//  - Shifts the word out serially while capturing ser_in, one bit every DIV clocks.
//  - Returns the captured word over a second valid/ready handshake.
//  - Sits between a host/register interface and a serial link: the controller that drives the shift register.
// PARAMETERS
//  WIDTH  4  shift register length in bits; legal range >= 2
//  DIV    1  clk cycles per bit period; legal range >= 1 (DIV=1 shifts every cycle)
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      synchronous, active-high; priority over all other inputs
//  start_valid  in   1      request a transfer
//  start_ready  out  1      high only in IDLE
//  start_dir    in   1      1 = shift left (MSB first out); 0 = shift right (LSB first out)
//  start_data   in   WIDTH  word to load; sampled only on the accepting edge
//  ser_in       in   1      serial input; sampled only on shift edges
//  ser_out      out  1      serial output bit of the current bit period
//  shift_en     out  1      high in the cycle whose closing edge performs a shift
//  busy         out  1      high in SHIFT and DONE
//  done_valid   out  1      captured word available
//  done_data    out  WIDTH  captured word; stable while done_valid=1
//  done_ready   in   1      consumer accepts done_data
// BEHAVIOUR
//  Reset (clk edge with reset=1):
//  - state=IDLE; shreg=0; bit_cnt=0; div_cnt=0.
//  - Outputs: ser_out=0, shift_en=0, busy=0, done_valid=0, done_data=0, start_ready=1.
//  - Reset mid-transfer aborts it: no done_valid, partial data discarded.
//  State machine:
//  - IDLE: start_ready=1. Edge with start_valid=1 -> load shreg=start_data, latch dir, clear counters, go SHIFT.
//  - SHIFT:
//    - ser_out = dir ? shreg[WIDTH-1] : shreg[0]; registered, so stable for the whole bit period.
//    - div_cnt counts 0..DIV-1. shift_en = (div_cnt==DIV-1), combinational from state and div_cnt.
//    - Shift edge, dir=1: shreg <= {shreg[WIDTH-2:0], ser_in}.
//    - Shift edge, dir=0: shreg <= {ser_in, shreg[WIDTH-1:1]}.
//    - Every shift edge: bit_cnt++, div_cnt <= 0.
//    - On the shift edge with bit_cnt==WIDTH-1: done_data <= shifted value; go DONE.
//  - DONE:
//    - done_valid=1; ser_out holds its last value.
//    - Edge with done_ready=1 -> IDLE and done_valid=0; start_ready rises the following cycle.
//  Timing and handshakes:
//  - Latency: done_valid rises WIDTH*DIV cycles after the accepting edge.
//  - Exactly WIDTH shift_en pulses per transfer.
//  - done_ready already high on entry to DONE: done_valid still asserts for exactly one cycle.
//  - start_valid outside IDLE is ignored; it is neither queued nor acknowledged.
//  - start_dir and start_data may change freely after acceptance; the latched copies are used.
//  Width rules:
//  - bit_cnt width = $clog2(WIDTH); div_cnt width = max(1, $clog2(DIV)).
//  - Neither counter wraps past its terminal value.
// STRUCTURE
//  - Shared package bsr_pkg:
//    - state encoding IDLE=2'b00, SHIFT=2'b01, DONE=2'b10
//    - DIR_LEFT=1'b1, DIR_RIGHT=1'b0
//  - One sub-module, bsr_core: WIDTH-bit bidirectional shift register.
//    - Ports: clk, reset, load, load_data, shift, mode, ser_in.
//    - Outputs: q, msb, lsb.
//  - This block holds the FSM, counters, handshakes and the done_data register.
// TESTING (WIDTH=4 unless noted)
//  1. Left: DIV=1, start_data=4'b1011, dir=1, ser_in=0 -> ser_out 1,0,1,1 on consecutive cycles; done_data=4'b0000; done_valid 4 cycles after accept.
//  2. Right: DIV=1, start_data=4'b1011, dir=0, ser_in=1 -> ser_out 1,1,0,1; done_data=4'b1111.
//  3. Loopback: ser_in tied to ser_out, dir=1, start_data=4'b1001 -> done_data=4'b1001.
//  4. Divider: DIV=3, dir=0, start_data=4'b0110 -> shift_en every 3rd cycle; each ser_out bit held 3 cycles; done_valid 12 cycles after accept.
//  5. Abort: reset=1 for one cycle after the 2nd shift_en -> next cycle state IDLE, start_ready=1, ser_out=0; done_valid never rises.
//  6. Backpressure: done_ready=0 for 5 cycles, start_valid=1 throughout.
//     -> done_valid and done_data held, start_ready=0.
//     -> After the done_ready=1 edge: done_valid=0, start_ready=1 next cycle, new transfer accepted.

Source files
------------

// File: rtl/bsr_pkg.sv
// Shared constants for the bidirectional shift sequencer: FSM state codes,
// shift direction codes and a counter-width helper.
package bsr_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Counter width for a count of n states, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsr_core.sv
// WIDTH-bit bidirectional shift register with parallel load.
// Load has priority over shift; mode selects the shift direction.
module bsr_core
    import bsr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             msb,
    output logic             lsb
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            if (mode == DIR_LEFT) begin
                q <= {q[WIDTH-2:0], ser_in};
            end else begin
                q <= {ser_in, q[WIDTH-1:1]};
            end
        end
    end

    assign msb = q[WIDTH-1];
    assign lsb = q[0];

endmodule

// File: rtl/bidir_shift_sequencer.sv
// Controller for one full serial transfer through bsr_core: start handshake,
// bit-period divider, bit counter, and the captured-word return handshake.
module bidir_shift_sequencer
    import bsr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             start_dir,
    input  logic [WIDTH-1:0] start_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic             done_valid,
    output logic [WIDTH-1:0] done_data,
    input  logic             done_ready
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int DCW = cnt_width(DIV);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    logic [1:0]       state;
    logic             dir;
    logic [BCW-1:0]   bit_cnt;
    logic [DCW-1:0]   div_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             shreg_msb;
    logic             shreg_lsb;
    logic             cur_bit;
    logic             ser_hold;
    logic             accept;

    assign start_ready = (state == IDLE);
    assign busy        = (state == SHIFT) || (state == DONE);
    assign done_valid  = (state == DONE);
    assign accept      = start_ready && start_valid;
    assign shift_en    = (state == SHIFT) && (div_cnt == DIV_LAST);

    bsr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_data(start_data),
        .shift    (shift_en),
        .mode     (dir),
        .ser_in   (ser_in),
        .q        (shreg),
        .msb      (shreg_msb),
        .lsb      (shreg_lsb)
    );

    // The value the core will hold after this shift edge; captured into
    // done_data on the final edge so the result is ready as DONE is entered.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shifted = {ser_in, shreg[WIDTH-1:1]};
        if (dir == DIR_LEFT) begin
            shifted = {shreg[WIDTH-2:0], ser_in};
        end
    end

    assign cur_bit = (dir == DIR_LEFT) ? shreg_msb : shreg_lsb;

    // ser_out is a mux of flops only: the live register bit while shifting,
    // otherwise the last transmitted bit (zero after reset).
    assign ser_out = (state == SHIFT) ? cur_bit : ser_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= DIR_RIGHT;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            done_data <= '0;
            ser_hold  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        dir     <= start_dir;
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            done_data <= shifted;
                            ser_hold  <= cur_bit;
                            state     <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_shift_sequencer.sv
// Self-checking bench: two instances (DIV=1 and DIV=3, WIDTH=4) driven by
// directed and randomized transfers, checked against a bit-level model.
module tb_bidir_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start_valid;
    logic [1:0] start_dir;
    logic [1:0] ser_in_drv;
    logic [1:0] ser_in;
    logic [1:0] done_ready;
    logic [1:0] loopback;
    logic [3:0] start_data [2];
    wire  [1:0] start_ready;
    wire  [1:0] ser_out;
    wire  [1:0] shift_en;
    wire  [1:0] busy;
    wire  [1:0] done_valid;
    wire  [3:0] done_data [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ser_in[i] = loopback[i] ? ser_out[i] : ser_in_drv[i];
        end
    end

    bidir_shift_sequencer #(.WIDTH(4), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .start_valid(start_valid[0]), .start_ready(start_ready[0]),
        .start_dir(start_dir[0]), .start_data(start_data[0]),
        .ser_in(ser_in[0]), .ser_out(ser_out[0]), .shift_en(shift_en[0]),
        .busy(busy[0]), .done_valid(done_valid[0]), .done_data(done_data[0]),
        .done_ready(done_ready[0])
    );

    bidir_shift_sequencer #(.WIDTH(4), .DIV(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .start_valid(start_valid[1]), .start_ready(start_ready[1]),
        .start_dir(start_dir[1]), .start_data(start_data[1]),
        .ser_in(ser_in[1]), .ser_out(ser_out[1]), .shift_en(shift_en[1]),
        .busy(busy[1]), .done_valid(done_valid[1]), .done_data(done_data[1]),
        .done_ready(done_ready[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int idx);
        int n = 0;
        while (start_ready[idx] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ready_wait", start_ready[idx], 1);
    endtask

    // One complete transfer. bits_in[k] is the serial bit offered on the k-th
    // shift edge (ignored in loopback). hold = cycles spent in DONE with
    // done_ready low (0 = done_ready already high on entry).
    task automatic xfer(input int idx, input logic [3:0] data, input logic dir,
                        input bit loop, input logic [3:0] bits_in,
                        input int hold, input bit keep_valid);
        int         div;
        logic [3:0] exp_done;
        logic       out_bit;
        logic       in_bit;
        int         k;
        div = (idx == 0) ? 1 : 3;
        exp_done = '0;
        out_bit = 1'b0;
        wait_ready(idx);
        start_valid[idx] = 1'b1;
        start_data[idx]  = data;
        start_dir[idx]   = dir;
        loopback[idx]    = loop;
        done_ready[idx]  = (hold == 0);
        tick();
        if (!keep_valid) start_valid[idx] = 1'b0;
        start_data[idx] = 4'($urandom);
        start_dir[idx]  = 1'($urandom);
        for (int c = 0; c < 4 * div; c++) begin
            k = c / div;
            // Transmit order: MSB first when shifting left, LSB first when right.
            out_bit = data[dir ? 3 - k : k];
            check("busy", busy[idx], 1);
            check("start_ready_shift", start_ready[idx], 0);
            check("done_valid_early", done_valid[idx], 0);
            check("ser_out", ser_out[idx], out_bit);
            check("shift_en", shift_en[idx], (c % div) == (div - 1));
            ser_in_drv[idx] = ((c % div) == (div - 1)) ? bits_in[k] : 1'($urandom);
            in_bit = loop ? out_bit : bits_in[k];
            // First received bit ends at the far end: bit 3-k (left) or k (right).
            exp_done[dir ? 3 - k : k] = in_bit;
            tick();
        end
        check("done_valid", done_valid[idx], 1);
        check("done_data", done_data[idx], exp_done);
        check("ser_out_hold", ser_out[idx], out_bit);
        check("shift_en_done", shift_en[idx], 0);
        check("start_ready_done", start_ready[idx], 0);
        for (int h = 1; h < hold; h++) begin
            tick();
            check("bp_done_valid", done_valid[idx], 1);
            check("bp_done_data", done_data[idx], exp_done);
            check("bp_start_ready", start_ready[idx], 0);
        end
        done_ready[idx] = 1'b1;
        tick();
        done_ready[idx] = 1'b0;
        loopback[idx]   = 1'b0;
        check("done_valid_drop", done_valid[idx], 0);
        check("start_ready_back", start_ready[idx], 1);
        check("busy_drop", busy[idx], 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start_valid = '0; start_dir = '0; ser_in_drv = '0;
        done_ready = '0; loopback = '0;
        start_data[0] = '0; start_data[1] = '0;
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check("rst_start_ready", start_ready[i], 1);
            check("rst_busy", busy[i], 0);
            check("rst_done_valid", done_valid[i], 0);
            check("rst_shift_en", shift_en[i], 0);
            check("rst_ser_out", ser_out[i], 0);
            check("rst_done_data", done_data[i], 0);
        end

        xfer(0, 4'b1011, 1'b1, 1'b0, 4'b0000, 0, 1'b0);
        xfer(0, 4'b1011, 1'b0, 1'b0, 4'b1111, 0, 1'b0);
        xfer(0, 4'b1001, 1'b1, 1'b1, 4'b0000, 0, 1'b0);
        xfer(1, 4'b0110, 1'b0, 1'b0, 4'($urandom), 0, 1'b0);

        // Abort: reset for one cycle after the second shift edge.
        wait_ready(0);
        start_valid[0] = 1'b1;
        start_data[0]  = 4'b1110;
        start_dir[0]   = 1'b1;
        done_ready[0]  = 1'b1;
        tick();
        start_valid[0] = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_start_ready", start_ready[0], 1);
        check("abort_ser_out", ser_out[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_done_data", done_data[0], 0);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_done", done_valid[0], 0);
            tick();
        end
        done_ready[0] = 1'b0;

        // Backpressure with start_valid held high throughout.
        xfer(0, 4'($urandom), 1'($urandom), 1'b0, 4'($urandom), 5, 1'b1);
        tick();
        check("bp_reaccept_busy", busy[0], 1);
        check("bp_reaccept_ready", start_ready[0], 0);
        start_valid[0] = 1'b0;
        n = 0;
        while (done_valid[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("bp_second_latency", n, 4);
        done_ready[0] = 1'b1;
        tick();
        done_ready[0] = 1'b0;
        check("bp_second_drop", done_valid[0], 0);

        for (int r = 0; r < 10; r++) begin
            xfer($urandom_range(0, 1), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 4'($urandom),
                 $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "simulation time limit reached");
    end

endmodule
